ibex_alu_pext_mac_seq: RTL

Multi-cycle 32x32 multiply-accumulate sequencer for the Pext 32-bit MAC ops (KMMAC/KMMACu, KMMSB/KMMSBu, MADDR32, MSUBR32). It sits directly downstream of the Pext ALU control decoder and consumes its signed/subtract decode. It iterates one 17x17 signed multiplier over four partial products, then accumulates, rounds and saturates. The result is returned over a valid/ready handshake to the writeback mux, together with an OV (vxsat) set pulse.

---
 rtl/ibex_pkg_pext.sv | 21 ++
 rtl/ibex_pext_mul17.sv | 21 ++
 rtl/ibex_alu_pext_mac_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg_pext.sv
// ibex_pkg_pext
// Shared types and constants for the Pext 32-bit multiply-accumulate path.
//   pext_mac_state_e : sequencer states (IDLE, four multiply steps, ACC, DONE)
//   PEXT_INT32_MAX   : 34-bit signed upper saturation bound (2^31-1)
//   PEXT_INT32_MIN   : 34-bit signed lower saturation bound (-2^31)
package ibex_pkg_pext;

  typedef enum logic [2:0] {
    MAC_IDLE = 3'd0,
    MAC_MUL0 = 3'd1,
    MAC_MUL1 = 3'd2,
    MAC_MUL2 = 3'd3,
    MAC_MUL3 = 3'd4,
    MAC_ACC  = 3'd5,
    MAC_DONE = 3'd6
  } pext_mac_state_e;

  localparam logic [33:0] PEXT_INT32_MAX = 34'h0_7FFF_FFFF;
  localparam logic [33:0] PEXT_INT32_MIN = 34'h3_8000_0000;

endpackage

// File: rtl/ibex_pext_mul17.sv
// ibex_pext_mul17
// Combinational 17x17 signed multiplier producing a full 34-bit product.
//   a : 17-bit signed multiplicand
//   b : 17-bit signed multiplier
//   p : 34-bit signed product
module ibex_pext_mul17 (
  input  logic [16:0] a,
  input  logic [16:0] b,
  output logic [33:0] p
);

  // Both operands are sign-extended to the product width first, so the
  // low 34 bits of the unsigned multiply equal the signed product.
  logic [33:0] a_ext;
  logic [33:0] b_ext;

  assign a_ext = {{17{a[16]}}, a};
  assign b_ext = {{17{b[16]}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/ibex_alu_pext_mac_seq.sv
// ibex_alu_pext_mac_seq
// Multi-cycle 32x32 multiply-accumulate sequencer for the Pext MAC ops
// (KMMAC/KMMACu, KMMSB/KMMSBu, MADDR32, MSUBR32). One 17x17 multiplier is
// reused over four cycles, then one cycle accumulates, rounds and saturates.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   valid_i / ready_o   : request handshake (ready_o only in IDLE)
//   op_a_i/op_b_i/op_c_i: multiplicand, multiplier, accumulator
//   signed_i, sub_i, high_i, round_i, sat_i : operation controls
//   kill_i              : abort an in-flight operation
//   valid_o / ready_i   : result handshake
//   result_o, ov_o      : result and saturation flag (held while valid_o)
module ibex_alu_pext_mac_seq
  import ibex_pkg_pext::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [31:0] op_c_i,
  input  logic        signed_i,
  input  logic        sub_i,
  input  logic        high_i,
  input  logic        round_i,
  input  logic        sat_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        ov_o
);

  pext_mac_state_e state, state_next;

  logic [31:0] a_q, b_q, c_q;
  logic        signed_q, sub_q, high_q, round_q, sat_q;
  logic [63:0] product_q;
  logic [31:0] result_q;
  logic        ov_q;

  logic        accept;
  logic [16:0] a_lo, a_hi, b_lo, b_hi;
  logic [16:0] mul_a, mul_b;
  logic [33:0] mul_p;
  logic [63:0] pp_ext;
  logic [63:0] pp_shifted;

  logic [63:0] p_round;
  logic [31:0] t;
  logic [33:0] c_ext, t_ext, sum;
  logic [31:0] acc_result;
  logic        acc_ov;

  // kill_i in IDLE blocks a same-cycle request.
  assign accept = (state == MAC_IDLE) && valid_i && !kill_i;

  // Low halves are always unsigned; high halves carry the sign only for
  // signed operations.
  assign a_lo = {1'b0, a_q[15:0]};
  assign b_lo = {1'b0, b_q[15:0]};
  assign a_hi = {signed_q & a_q[31], a_q[31:16]};
  assign b_hi = {signed_q & b_q[31], b_q[31:16]};

  ibex_pext_mul17 u_mul17 (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  assign pp_ext = {{30{mul_p[33]}}, mul_p};

  // Operand selection and partial-product alignment per multiply step.
  always_comb begin
    mul_a      = a_lo;
    mul_b      = b_lo;
    pp_shifted = pp_ext;
    unique case (state)
      MAC_MUL1: begin
        mul_a      = a_lo;
        mul_b      = b_hi;
        pp_shifted = pp_ext << 16;
      end
      MAC_MUL2: begin
        mul_a      = a_hi;
        mul_b      = b_lo;
        pp_shifted = pp_ext << 16;
      end
      MAC_MUL3: begin
        mul_a      = a_hi;
        mul_b      = b_hi;
        pp_shifted = pp_ext << 32;
      end
      default: ;
    endcase
  end

  // Accumulate stage. The high word is taken after rounding so the round
  // carry propagates into it; the low word path ignores rounding.
  always_comb begin
    p_round    = product_q + (round_q ? 64'h0000_0000_8000_0000 : 64'd0);
    t          = high_q ? p_round[63:32] : product_q[31:0];
    c_ext      = {{2{c_q[31]}}, c_q};
    t_ext      = {{2{t[31]}}, t};
    sum        = sub_q ? (c_ext - t_ext) : (c_ext + t_ext);
    acc_result = sum[31:0];
    acc_ov     = 1'b0;
    if (sat_q) begin
      if ($signed(sum) > $signed(PEXT_INT32_MAX)) begin
        acc_result = PEXT_INT32_MAX[31:0];
        acc_ov     = 1'b1;
      end else if ($signed(sum) < $signed(PEXT_INT32_MIN)) begin
        acc_result = PEXT_INT32_MIN[31:0];
        acc_ov     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= MAC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; kill_i overrides every busy state.
  always_comb begin
    state_next = state;
    unique case (state)
      MAC_IDLE: if (accept) state_next = MAC_MUL0;
      MAC_MUL0: state_next = MAC_MUL1;
      MAC_MUL1: state_next = MAC_MUL2;
      MAC_MUL2: state_next = MAC_MUL3;
      MAC_MUL3: state_next = MAC_ACC;
      MAC_ACC:  state_next = MAC_DONE;
      MAC_DONE: if (ready_i) state_next = MAC_IDLE;
      default:  state_next = MAC_IDLE;
    endcase
    if (kill_i && (state != MAC_IDLE)) begin
      state_next = MAC_IDLE;
    end
  end

  // Operand latches, product accumulation and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      c_q       <= 32'd0;
      signed_q  <= 1'b0;
      sub_q     <= 1'b0;
      high_q    <= 1'b0;
      round_q   <= 1'b0;
      sat_q     <= 1'b0;
      product_q <= 64'd0;
      result_q  <= 32'd0;
      ov_q      <= 1'b0;
    end else begin
      unique case (state)
        MAC_IDLE: begin
          if (accept) begin
            a_q       <= op_a_i;
            b_q       <= op_b_i;
            c_q       <= op_c_i;
            signed_q  <= signed_i;
            sub_q     <= sub_i;
            high_q    <= high_i;
            round_q   <= round_i;
            sat_q     <= sat_i;
            product_q <= 64'd0;
          end
        end
        MAC_MUL0, MAC_MUL1, MAC_MUL2, MAC_MUL3: begin
          product_q <= product_q + pp_shifted;
        end
        MAC_ACC: begin
          if (!kill_i) begin
            result_q <= acc_result;
            ov_q     <= acc_ov;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state == MAC_IDLE);
  assign valid_o  = (state == MAC_DONE);
  assign result_o = result_q;
  assign ov_o     = ov_q;

endmodule
